board_ram: RTL and testbench

- Parametrised word-addressed data RAM on the CPU data bus, mapped into a fixed address window (game-board storage and successors).
- Adds byte-enable writes, a registered read with a valid/ready request-response handshake, and error reporting for out-of-window or misaligned accesses.
- Adds a sequential clear engine that sweeps the array to a fill value, so the storage maps to block RAM instead of a reset-cleared register array.

---
 rtl/board_ram.sv | 124 ++++++++++++
 tb/tb_board_ram.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/board_ram.sv
// Word-addressed data RAM in a fixed byte-address window. Supports byte-enable writes,
// reads with a registered one-cycle response, and a sequential clear sweep on reset/clr_start.
module board_ram #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 100,
  parameter logic [31:0]       BASE_ADDR = 32'h1000,
  parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  input  logic                  clr_start_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o
);
  // state    | meaning
  // ST_CLEAR | sweeping CLR_VAL into word k, one word per cycle; bus not ready
  // ST_IDLE  | serving bus accesses, one per cycle
  localparam int                 BE_W      = DATA_W / 8;
  localparam int                 IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]   K_LAST    = IDX_W'(DEPTH - 1);
  localparam logic [32:0]        WIN_BYTES = 33'(4 * DEPTH);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic              clr_done_q, clr_done_d;
  logic              rsp_valid_q, rsp_err_q, rsp_rd_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]       off;
  logic              addr_ok;
  logic              accept;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    off     = req_addr_i - BASE_ADDR;
    addr_ok = (req_addr_i >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES) &&
              (req_addr_i[1:0] == 2'b00);
    idx     = IDX_W'(off >> 2);
    accept  = req_valid_i && req_ready_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_CLEAR;
      k_q        <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (k_q == K_LAST) begin
          state_d    = ST_IDLE;
          k_d        = '0;
          clr_done_d = 1'b1;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (clr_start_i) begin
          state_d = ST_CLEAR;
          k_d     = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Response fields are gated by rsp_valid so they read as zero between responses.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    clr_busy_o  = (state_q == ST_CLEAR);
    clr_done_o  = clr_done_q;
    rsp_valid_o = rsp_valid_q;
    rsp_err_o   = rsp_valid_q && rsp_err_q;
    rsp_rdata_o = (rsp_valid_q && rsp_rd_q) ? rdata_q : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && !addr_ok;
      rsp_rd_q    <= accept && !req_we_i && addr_ok;
    end
  end

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem[k_q] <= CLR_VAL;
    end else if (accept && req_we_i && addr_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be_i[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
    if (accept && !req_we_i && addr_ok) rdata_q <= mem[idx];
  end

endmodule

// File: tb/tb_board_ram.sv
// Randomized plus directed bench for board_ram against a word-array reference model
// that tracks sweep length, acceptance and byte-enable merges.
module tb_board_ram;
  localparam int          DEPTH   = 100;
  localparam logic [31:0] BASE    = 32'h1000;
  localparam logic [31:0] CLR_VAL = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        clr_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_rem;

  always #5 clk = ~clk;

  board_ram #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .CLR_VAL(CLR_VAL)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    longint la = longint'(a);
    return (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH) || (la % 4 != 0);
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_rem  = DEPTH;
  endtask

  // One clock: pre-edge checks, model update, post-edge checks.
  task automatic step();
    bit          acc, bad;
    int          idx;
    logic [31:0] e_rdata;
    bit          e_done;
    check_eq("req_ready", req_ready, !m_busy);
    check_eq("clr_busy", clr_busy, m_busy);
    bad     = addr_bad(req_addr);
    idx     = bad ? 0 : int'((req_addr - BASE) / 4);
    acc     = req_valid && !m_busy;
    e_rdata = (acc && !req_we && !bad) ? m_mem[idx] : 32'h0;
    if (acc && req_we && !bad)
      for (int b = 0; b < 4; b++)
        if (req_be[b]) m_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
    e_done = 1'b0;
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        e_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = CLR_VAL;
      end
    end else if (clr_start) begin
      m_busy = 1'b1;
      m_rem  = DEPTH;
    end
    @(posedge clk);
    #1;
    check_eq("rsp_valid", rsp_valid, acc);
    check_eq("rsp_err", rsp_err, acc && bad);
    check_eq("rsp_rdata", rsp_rdata, e_rdata);
    check_eq("clr_done", clr_done, e_done);
  endtask

  task automatic op(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, input bit clr);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; clr_start = clr;
    step();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic run_sweep(input string tag, input int restart_at);
    int cnt = 0;
    int dn  = 0;
    req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      clr_start = (i == restart_at);
      if (clr_busy) cnt++;
      step();
      if (clr_done) dn++;
      if (!clr_busy) break;
    end
    clr_start = 1'b0;
    check_eq({tag, "_len"}, cnt, DEPTH);
    check_eq({tag, "_done"}, dn, 1);
    check_eq({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, rsp_valid, 0);
    check_eq({tag, "_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_err"}, rsp_err, 0);
    check_eq({tag, "_done"}, clr_done, 0);
    check_eq({tag, "_busy"}, clr_busy, 1);
    check_eq({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    req_valid = 1'b0; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    rst = 1'b0;
    run_sweep("rst_sweep", -1);

    op(1, 0, 32'h1000, 0, 0, 0);
    check_eq("rd_1000", rsp_rdata, 32'h0);
    op(1, 0, 32'h118C, 0, 0, 0);
    check_eq("rd_118c_err", rsp_err, 0);

    op(1, 1, 32'h1004, 32'hDEADBEEF, 4'hF, 0);
    op(1, 1, 32'h1004, 32'h00001200, 4'b0010, 0);
    op(1, 0, 32'h1004, 0, 0, 0);
    check_eq("be_merge", rsp_rdata, 32'hDEAD12EF);
    op(1, 1, 32'h1004, 32'hFFFFFFFF, 4'h0, 0);
    op(1, 0, 32'h1004, 0, 0, 0);
    check_eq("be_zero", rsp_rdata, 32'hDEAD12EF);
    idle();

    op(1, 1, 32'h1190, 32'h12345678, 4'hF, 0);
    check_eq("err_1190", rsp_err, 1);
    op(1, 1, 32'h0FFC, 32'h12345678, 4'hF, 0);
    check_eq("err_0ffc", rsp_err, 1);
    op(1, 0, 32'h1002, 0, 0, 0);
    check_eq("err_1002", rsp_err, 1);
    check_eq("err_1002_rdata", rsp_rdata, 0);
    op(1, 0, 32'h1000, 0, 0, 0);
    check_eq("rd_1000_after_err", rsp_rdata, 32'h0);
    idle();

    op(1, 1, 32'h1008, 32'h11, 4'hF, 0);
    check_eq("b2b_v0", rsp_valid, 1);
    op(1, 0, 32'h1008, 0, 0, 0);
    check_eq("b2b_raw", rsp_rdata, 32'h11);
    op(1, 0, 32'h100C, 0, 0, 0);
    check_eq("b2b_next", rsp_rdata, 32'h0);
    idle();

    op(1, 1, 32'h1010, 32'h55, 4'hF, 1);
    check_eq("clr_wr_rsp", rsp_valid, 1);
    run_sweep("clr_sweep", 30);
    op(1, 0, 32'h1010, 0, 0, 0);
    check_eq("clr_rd_1010", rsp_rdata, CLR_VAL);
    op(1, 0, 32'h1004, 0, 0, 0);
    check_eq("clr_rd_1004", rsp_rdata, CLR_VAL);

    op(1, 1, 32'h1014, 32'hA5A5A5A5, 4'hF, 0);
    op(1, 0, 32'h1014, 0, 0, 0);
    check_eq("rd_1014", rsp_rdata, 32'hA5A5A5A5);
    async_reset("rst_mid_rsp");
    run_sweep("rsp_rst_sweep", -1);

    op(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) idle();
    async_reset("rst_mid_sweep");
    run_sweep("mid_rst_sweep", -1);

    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 19));
      if (kind < 17) a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      else if (kind == 17) a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (kind == 18) a = ($urandom_range(0, 1) == 0) ? BASE - 4 : BASE + 4 * DEPTH;
      else a = $urandom;
      op($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, a, $urandom,
         4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 200 && m_busy; i++) idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
